cr_lz77_comp_sym_sched: RTL and testbench

//  Symbol scheduler between the LZ77 match output stage and the downstream encoder.

---
 rtl/cr_lz77_comp_pkg.sv | 15 +
 rtl/cr_lz77_comp_sym_sched_if.sv | 29 ++
 rtl/cr_lz77_comp_sym_q.sv | 70 +++++++
 rtl/cr_lz77_comp_sym_sched.sv | 215 +++++++++++++++++++++
 tb/tb_cr_lz77_comp_sym_sched.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cr_lz77_comp_pkg.sv
// Shared LZ77 compressor types: symbol type encoding and the scheduler input width.
package cr_lz77_comp_pkg;

   typedef enum logic [1:0] {
      SYM_NULL = 2'd0,
      SYM_LIT  = 2'd1,
      SYM_PTR  = 2'd2,
      SYM_MTF  = 2'd3
   } lz77_symbol_type_e;

   // Slots in one compacted input bundle: up to 4 literals plus one PTR/MTF.
   localparam int SYM_IN_SLOTS = 5;
   localparam int SYM_LIT_SLOTS = 4;

endpackage

// File: rtl/cr_lz77_comp_sym_sched_if.sv
// Bundle input / symbol output bus of the LZ77 symbol scheduler.
// master = producer of bundles and consumer of symbols; slave = the scheduler.
interface cr_lz77_comp_sym_sched_if #(
   parameter int LEN_W = 12,
   parameter int OFF_W = 12,
   parameter int OUT_N = 2
);
   logic [4:0][1:0]                        in_type;
   logic [3:0][7:0]                        in_lit;
   logic [LEN_W-1:0]                       in_len;
   logic [OFF_W-1:0]                       in_off;
   logic                                   in_last;
   logic                                   xoff;
   logic [OUT_N-1:0]                       out_valid;
   logic [OUT_N-1:0][1:0]                  out_type;
   logic [OUT_N-1:0][LEN_W+OFF_W-1:0]      out_data;
   logic                                   out_ready;
   logic                                   out_eof;

   modport master (
      output in_type, in_lit, in_len, in_off, in_last, out_ready,
      input  xoff, out_valid, out_type, out_data, out_eof
   );

   modport slave (
      input  in_type, in_lit, in_len, in_off, in_last, out_ready,
      output xoff, out_valid, out_type, out_data, out_eof
   );
endinterface

// File: rtl/cr_lz77_comp_sym_q.sv
// Circular symbol queue: writes up to SYM_IN_SLOTS entries and exposes OUT_N
// read lanes per cycle. The caller guarantees wr_n fits after the rd_n pop.
module cr_lz77_comp_sym_q
   import cr_lz77_comp_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int OUT_N = 2,
   parameter int DW    = 24,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = AW + 1
)
(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [2:0]                         wr_n,
   input  logic [SYM_IN_SLOTS-1:0][1:0]       wr_type,
   input  logic [SYM_IN_SLOTS-1:0][DW-1:0]    wr_data,
   input  logic [2:0]                         rd_n,
   output logic [CNT_W-1:0]                   count,
   output logic [OUT_N-1:0][1:0]              rd_type,
   output logic [OUT_N-1:0][DW-1:0]           rd_data
);

   logic [1:0]       mem_type_r [DEPTH];
   logic [DW-1:0]    mem_data_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CNT_W-1:0] count_r;

   // Store the first wr_n slots of the bundle in order starting at wr_ptr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < DEPTH; j++) begin
            mem_type_r[j] <= 2'b00;
            mem_data_r[j] <= {DW{1'b0}};
         end
      end else begin
         for (int i = 0; i < SYM_IN_SLOTS; i++) begin
            if (3'(i) < wr_n) begin
               mem_type_r[wr_ptr_r + AW'(i)] <= wr_type[i];
               mem_data_r[wr_ptr_r + AW'(i)] <= wr_data[i];
            end
         end
      end
   end

   // Advance pointers (wrap modulo DEPTH) and track occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_r <= wr_ptr_r + AW'(wr_n);
         rd_ptr_r <= rd_ptr_r + AW'(rd_n);
         count_r  <= count_r + CNT_W'(wr_n) - CNT_W'(rd_n);
      end
   end

   // Present the oldest OUT_N entries as read lanes.
   always_comb begin
      for (int k = 0; k < OUT_N; k++) begin
         rd_type[k] = mem_type_r[rd_ptr_r + AW'(k)];
         rd_data[k] = mem_data_r[rd_ptr_r + AW'(k)];
      end
   end

   assign count = count_r;

endmodule

// File: rtl/cr_lz77_comp_sym_sched.sv
// LZ77 symbol scheduler: validates compacted bundles, queues their symbols,
// drains up to OUT_N per cycle, raises advisory xoff and sequences end-of-frame.
module cr_lz77_comp_sym_sched
   import cr_lz77_comp_pkg::*;
#(
   parameter int LEN_W   = 12,
   parameter int OFF_W   = 12,
   parameter int DEPTH   = 16,
   parameter int OUT_N   = 2,
   parameter int XOFF_TH = 8
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   cr_lz77_comp_sym_sched_if.slave  bus,
   output logic [15:0]              frame_syms,
   output logic [1:0]               err
);

   localparam int DW    = LEN_W + OFF_W;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(DEPTH);
   localparam logic [CNT_W:0] XOFF_W  = (CNT_W+1)'(XOFF_TH);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_EOF    = 2'd3;

   logic [1:0]                        state_r;
   logic [1:0]                        state_s;
   logic [15:0]                       frame_syms_r;
   logic [1:0]                        err_r;
   logic                              xoff_r;

   logic [2:0]                        nwr_s;
   logic                              lead_s;
   logic                              proto_ok_s;
   logic                              any_sym_s;
   logic [SYM_IN_SLOTS-1:0][1:0]      wr_type_s;
   logic [SYM_IN_SLOTS-1:0][DW-1:0]   wr_data_s;

   logic [CNT_W-1:0]                  count_s;
   logic [OUT_N-1:0][1:0]             q_type_s;
   logic [OUT_N-1:0][DW-1:0]          q_data_s;
   logic [2:0]                        avail_s;
   logic [2:0]                        nrd_s;
   logic [CNT_W:0]                    room_s;
   logic                              in_open_s;
   logic                              wr_ok_s;
   logic                              ovf_s;
   logic                              perr_s;
   logic [2:0]                        wr_n_s;
   logic [CNT_W-1:0]                  count_next_s;
   logic [CNT_W:0]                    free_next_s;
   logic                              eof_s;
   logic [16:0]                       frame_sum_s;
   logic [15:0]                       frame_add_s;

   // Bundle compaction check: count leading non-NULL slots and validate placement.
   always_comb begin
      nwr_s      = 3'd0;
      lead_s     = 1'b1;
      proto_ok_s = 1'b1;
      for (int i = 0; i < SYM_IN_SLOTS; i++) begin
         if (bus.in_type[i] != SYM_NULL) begin
            if (lead_s) begin
               nwr_s = nwr_s + 3'd1;
            end else begin
               proto_ok_s = 1'b0;
            end
         end else begin
            lead_s = 1'b0;
         end
      end
      if (bus.in_type[SYM_IN_SLOTS-1] == SYM_LIT) begin
         proto_ok_s = 1'b0;
      end else begin
         proto_ok_s = proto_ok_s;
      end
      // Every symbol before the last one must be a literal: one PTR/MTF at most, and last.
      for (int i = 0; i < SYM_LIT_SLOTS; i++) begin
         if ((3'(i) + 3'd1 < nwr_s) && (bus.in_type[i] != SYM_LIT)) begin
            proto_ok_s = 1'b0;
         end else begin
            proto_ok_s = proto_ok_s;
         end
      end
      any_sym_s = |bus.in_type;
   end

   // Format each slot as a queue entry: literal zero-extended, or {len, off}.
   always_comb begin
      for (int i = 0; i < SYM_LIT_SLOTS; i++) begin
         wr_type_s[i] = bus.in_type[i];
         if (bus.in_type[i] == SYM_LIT) begin
            wr_data_s[i] = {{(DW-8){1'b0}}, bus.in_lit[i]};
         end else begin
            wr_data_s[i] = {bus.in_len, bus.in_off};
         end
      end
      wr_type_s[SYM_IN_SLOTS-1] = bus.in_type[SYM_IN_SLOTS-1];
      wr_data_s[SYM_IN_SLOTS-1] = {bus.in_len, bus.in_off};
   end

   // Pop size, admission decision and next occupancy.
   always_comb begin
      if (count_s >= CNT_W'(OUT_N)) begin
         avail_s = 3'(OUT_N);
      end else begin
         avail_s = count_s[2:0];
      end
      nrd_s        = bus.out_ready ? avail_s : 3'd0;
      room_s       = DEPTH_W - {1'b0, count_s} + (CNT_W+1)'(nrd_s);
      in_open_s    = (state_r == ST_IDLE) || (state_r == ST_ACTIVE);
      wr_ok_s      = in_open_s && proto_ok_s && (nwr_s != 3'd0) && ((CNT_W+1)'(nwr_s) <= room_s);
      ovf_s        = in_open_s && proto_ok_s && (nwr_s != 3'd0) && ((CNT_W+1)'(nwr_s) > room_s);
      perr_s       = in_open_s ? !proto_ok_s : (any_sym_s || bus.in_last);
      wr_n_s       = wr_ok_s ? nwr_s : 3'd0;
      count_next_s = count_s + CNT_W'(wr_n_s) - CNT_W'(nrd_s);
      free_next_s  = DEPTH_W - {1'b0, count_next_s};
      eof_s        = ((state_r == ST_DRAIN) && (CNT_W'(nrd_s) == count_s) &&
                      (count_s <= CNT_W'(OUT_N))) || (state_r == ST_EOF);
      frame_sum_s  = {1'b0, frame_syms_r} + 17'(wr_n_s);
      frame_add_s  = frame_sum_s[16] ? 16'hFFFF : frame_sum_s[15:0];
   end

   // Frame sequencing: IDLE -> ACTIVE/DRAIN/EOF, drain to empty, back to IDLE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (wr_ok_s) begin
               state_s = bus.in_last ? ST_DRAIN : ST_ACTIVE;
            end else if (bus.in_last) begin
               state_s = ST_EOF;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            state_s = bus.in_last ? ST_DRAIN : ST_ACTIVE;
         end
         ST_DRAIN: begin
            state_s = (eof_s && bus.out_ready) ? ST_IDLE : ST_DRAIN;
         end
         ST_EOF: begin
            state_s = bus.out_ready ? ST_IDLE : ST_EOF;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, sticky errors, xoff and per-frame symbol counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         err_r        <= 2'b00;
         xoff_r       <= 1'b0;
         frame_syms_r <= 16'd0;
      end else begin
         state_r  <= state_s;
         err_r[0] <= err_r[0] | ovf_s;
         err_r[1] <= err_r[1] | perr_s;
         xoff_r   <= (free_next_s < XOFF_W);
         if (state_r == ST_IDLE) begin
            if (wr_ok_s) begin
               frame_syms_r <= 16'(nwr_s);
            end else if (bus.in_last) begin
               frame_syms_r <= 16'd0;
            end
         end else if (state_r == ST_ACTIVE) begin
            frame_syms_r <= frame_add_s;
         end
      end
   end

   cr_lz77_comp_sym_q #(
      .DEPTH (DEPTH),
      .OUT_N (OUT_N),
      .DW    (DW)
   ) u_sym_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_n    (wr_n_s),
      .wr_type (wr_type_s),
      .wr_data (wr_data_s),
      .rd_n    (nrd_s),
      .count   (count_s),
      .rd_type (q_type_s),
      .rd_data (q_data_s)
   );

   // Output lanes: valid contiguous from lane 0, unused lanes forced to zero.
   always_comb begin
      for (int k = 0; k < OUT_N; k++) begin
         bus.out_valid[k] = (CNT_W'(k) < count_s);
         if (bus.out_valid[k]) begin
            bus.out_type[k] = q_type_s[k];
            bus.out_data[k] = q_data_s[k];
         end else begin
            bus.out_type[k] = 2'b00;
            bus.out_data[k] = {DW{1'b0}};
         end
      end
   end

   assign bus.out_eof = eof_s;
   assign bus.xoff    = xoff_r;
   assign frame_syms  = frame_syms_r;
   assign err         = err_r;

endmodule

// File: tb/tb_cr_lz77_comp_sym_sched.sv
// Scoreboard bench for cr_lz77_comp_sym_sched (OUT_N = 2, DEPTH = 16, XOFF_TH = 8).
module tb_cr_lz77_comp_sym_sched;
   import cr_lz77_comp_pkg::*;

   localparam int LEN_W = 12;
   localparam int OFF_W = 12;
   localparam int DEPTH = 16;
   localparam int OUT_N = 2;
   localparam int XOFF_TH = 8;
   localparam int DW = LEN_W + OFF_W;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] frame_syms;
   logic [1:0]  err;

   cr_lz77_comp_sym_sched_if #(.LEN_W(LEN_W), .OFF_W(OFF_W), .OUT_N(OUT_N)) bus ();

   cr_lz77_comp_sym_sched #(
      .LEN_W(LEN_W), .OFF_W(OFF_W), .DEPTH(DEPTH), .OUT_N(OUT_N), .XOFF_TH(XOFF_TH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .frame_syms (frame_syms),
      .err        (err)
   );

   always #5 clk = ~clk;

   int            n_vec = 0;
   int            n_bad = 0;
   bit            mon_en = 1'b0;
   logic [DW+1:0] sb [$];
   logic [DW+1:0] mon_e;
   logic [4:0][1:0] blk;
   logic [4:0][1:0] bad_tab [3];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0][1:0] mk(input lz77_symbol_type_e a, input lz77_symbol_type_e b,
                                          input lz77_symbol_type_e c, input lz77_symbol_type_e d,
                                          input lz77_symbol_type_e e);
      logic [4:0][1:0] t;
      t[0] = a; t[1] = b; t[2] = c; t[3] = d; t[4] = e;
      return t;
   endfunction

   task automatic send(input logic [4:0][1:0] t, input logic [3:0][7:0] lits,
                       input logic [11:0] len, input logic [11:0] off,
                       input logic last, input bit acc);
      @(posedge clk); #1;
      bus.in_type = t;
      bus.in_lit  = lits;
      bus.in_len  = len;
      bus.in_off  = off;
      bus.in_last = last;
      if (acc) begin
         for (int i = 0; i < 5; i++) begin
            if (t[i] == SYM_LIT && i < 4)
               sb.push_back({t[i], 16'h0000, lits[i[1:0]]});
            else if (t[i] != SYM_NULL)
               sb.push_back({t[i], len, off});
         end
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      bus.in_type = '0;
      bus.in_last = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mon_en = 1'b0;
      sb.delete();
      bus.in_type = '0; bus.in_lit = '0; bus.in_len = '0; bus.in_off = '0;
      bus.in_last = 1'b0; bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic wait_eof(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (bus.out_eof && bus.out_ready) begin
            seen = 1'b1;
            break;
         end
      end
      check_val(tag, 32'(seen), 32'd1);
   endtask

   task automatic wait_empty(input string tag);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (bus.out_valid == '0) break;
      end
      check_val(tag, 32'(bus.out_valid), 32'd0);
   endtask

   // Scoreboard: every popped lane must match the oldest expected symbol.
   always @(negedge clk) begin
      if (rst_n && mon_en && bus.out_ready) begin
         for (int k = 0; k < OUT_N; k++) begin
            if (bus.out_valid[k]) begin
               if (sb.size() == 0) begin
                  check_val("unexp_lane", 32'(bus.out_valid[k]), 32'd0);
               end else begin
                  mon_e = sb.pop_front();
                  check_val("sym_type", 32'(bus.out_type[k]), 32'(mon_e[DW+1:DW]));
                  check_val("sym_data", 32'(bus.out_data[k]), 32'(mon_e[DW-1:0]));
               end
            end
         end
         if (bus.out_eof) check_val("eof_sb_empty", 32'(sb.size()), 32'd0);
      end
   end

   initial begin
      bus.in_type = '0; bus.in_lit = '0; bus.in_len = '0; bus.in_off = '0;
      bus.in_last = 1'b0; bus.out_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check_val("rst_xoff", 32'(bus.xoff), 32'd0);
      check_val("rst_valid", 32'(bus.out_valid), 32'd0);
      check_val("rst_eof", 32'(bus.out_eof), 32'd0);
      check_val("rst_fsyms", 32'(frame_syms), 32'd0);
      check_val("rst_err", 32'(err), 32'd0);
      do_reset();

      // Four bundles of {LIT 41,42,43, PTR 5/9}, drained 2 per cycle.
      bus.out_ready = 1'b1;
      blk = mk(SYM_LIT, SYM_LIT, SYM_LIT, SYM_PTR, SYM_NULL);
      send(blk, {8'h00, 8'h43, 8'h42, 8'h41}, 12'd5, 12'd9, 1'b0, 1'b1);
      check_val("lat_before", 32'(bus.out_valid), 32'd0);
      send(blk, {8'h00, 8'h43, 8'h42, 8'h41}, 12'd5, 12'd9, 1'b0, 1'b1);
      check_val("lat_first", 32'(bus.out_valid), 32'd3);
      send(blk, {8'h00, 8'h43, 8'h42, 8'h41}, 12'd5, 12'd9, 1'b0, 1'b1);
      send(blk, {8'h00, 8'h43, 8'h42, 8'h41}, 12'd5, 12'd9, 1'b1, 1'b1);
      check_val("xoff_free8", 32'(bus.xoff), 32'd0);
      idle();
      check_val("xoff_free6", 32'(bus.xoff), 32'd1);
      wait_eof("t2_eof");
      @(posedge clk); #1;
      check_val("t2_idle_valid", 32'(bus.out_valid), 32'd0);
      check_val("t2_idle_eof", 32'(bus.out_eof), 32'd0);
      check_val("t2_fsyms", 32'(frame_syms), 32'd16);
      check_val("t2_err", 32'(err), 32'd0);

      // Empty frame from IDLE.
      send('0, '0, 12'd0, 12'd0, 1'b1, 1'b0);
      idle();
      check_val("t3_eof", 32'(bus.out_eof), 32'd1);
      check_val("t3_valid", 32'(bus.out_valid), 32'd0);
      check_val("t3_fsyms", 32'(frame_syms), 32'd0);
      @(posedge clk); #1;
      check_val("t3_eof_gone", 32'(bus.out_eof), 32'd0);

      // Back-pressure: 5 per cycle, xoff, overflow drop of the fourth bundle.
      do_reset();
      blk = mk(SYM_LIT, SYM_LIT, SYM_LIT, SYM_LIT, SYM_MTF);
      send(blk, {8'h04, 8'h03, 8'h02, 8'h01}, 12'd7, 12'd3, 1'b0, 1'b1);
      send(blk, {8'h14, 8'h13, 8'h12, 8'h11}, 12'd8, 12'd4, 1'b0, 1'b1);
      check_val("t4_xoff_c5", 32'(bus.xoff), 32'd0);
      send(blk, {8'h24, 8'h23, 8'h22, 8'h21}, 12'd9, 12'd5, 1'b0, 1'b1);
      check_val("t4_xoff_c10", 32'(bus.xoff), 32'd1);
      send(blk, {8'h34, 8'h33, 8'h32, 8'h31}, 12'd10, 12'd6, 1'b0, 1'b0);
      check_val("t4_err_pre", 32'(err), 32'd0);
      idle();
      check_val("t4_err_ovf", 32'(err), 32'd1);
      bus.out_ready = 1'b1;
      wait_empty("t4_drain");
      check_val("t4_sb_left", 32'(sb.size()), 32'd0);
      send('0, '0, 12'd0, 12'd0, 1'b1, 1'b0);
      idle();
      wait_eof("t4_eof");
      check_val("t4_fsyms", 32'(frame_syms), 32'd15);

      // Protocol violations: bundle dropped, err[1] set.
      bad_tab[0] = mk(SYM_LIT, SYM_NULL, SYM_LIT, SYM_NULL, SYM_NULL);
      bad_tab[1] = mk(SYM_LIT, SYM_PTR, SYM_LIT, SYM_NULL, SYM_NULL);
      bad_tab[2] = mk(SYM_LIT, SYM_LIT, SYM_LIT, SYM_LIT, SYM_LIT);
      for (int p = 0; p < 3; p++) begin
         do_reset();
         send(mk(SYM_LIT, SYM_LIT, SYM_NULL, SYM_NULL, SYM_NULL),
              {8'h00, 8'h00, 8'h52, 8'h51}, 12'd0, 12'd0, 1'b0, 1'b1);
         send(bad_tab[p], {8'h99, 8'h98, 8'h97, 8'h96}, 12'd1, 12'd1, 1'b0, 1'b0);
         idle();
         check_val("t5_err_proto", 32'(err), 32'd2);
         bus.out_ready = 1'b1;
         wait_empty("t5_drain");
         repeat (2) @(negedge clk);
      end

      // Single last bundle of 3 symbols: beats of 2 then 1, eof on the second.
      do_reset();
      bus.out_ready = 1'b1;
      send(mk(SYM_LIT, SYM_LIT, SYM_PTR, SYM_NULL, SYM_NULL),
           {8'h00, 8'h00, 8'h62, 8'h61}, 12'd3, 12'h123, 1'b1, 1'b1);
      idle();
      check_val("t6_beat1_valid", 32'(bus.out_valid), 32'd3);
      check_val("t6_beat1_eof", 32'(bus.out_eof), 32'd0);
      @(posedge clk); #1;
      check_val("t6_beat2_valid", 32'(bus.out_valid), 32'd1);
      check_val("t6_beat2_eof", 32'(bus.out_eof), 32'd1);
      @(posedge clk); #1;
      check_val("t6_idle_valid", 32'(bus.out_valid), 32'd0);
      check_val("t6_idle_eof", 32'(bus.out_eof), 32'd0);
      check_val("t6_fsyms", 32'(frame_syms), 32'd3);

      // Asynchronous reset while draining 10 symbols, then a normal frame.
      do_reset();
      blk = mk(SYM_LIT, SYM_LIT, SYM_LIT, SYM_LIT, SYM_PTR);
      send(blk, {8'h74, 8'h73, 8'h72, 8'h71}, 12'd2, 12'd2, 1'b0, 1'b1);
      send(blk, {8'h84, 8'h83, 8'h82, 8'h81}, 12'd3, 12'd3, 1'b1, 1'b1);
      idle();
      check_val("t7_xoff_pre", 32'(bus.xoff), 32'd1);
      check_val("t7_fsyms_pre", 32'(frame_syms), 32'd10);
      #3;
      rst_n = 1'b0;
      mon_en = 1'b0;
      sb.delete();
      #1;
      check_val("t7_rst_valid", 32'(bus.out_valid), 32'd0);
      check_val("t7_rst_xoff", 32'(bus.xoff), 32'd0);
      check_val("t7_rst_eof", 32'(bus.out_eof), 32'd0);
      check_val("t7_rst_fsyms", 32'(frame_syms), 32'd0);
      check_val("t7_rst_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mon_en = 1'b1;
      bus.out_ready = 1'b1;
      send(mk(SYM_LIT, SYM_PTR, SYM_NULL, SYM_NULL, SYM_NULL),
           {8'h00, 8'h00, 8'h00, 8'h91}, 12'd4, 12'd7, 1'b1, 1'b1);
      idle();
      wait_eof("t7_eof");
      check_val("t7_fsyms", 32'(frame_syms), 32'd2);
      check_val("t7_err", 32'(err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
